// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, port owners and access direction.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_ACCESS  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic MEM_READ = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// ACCESS-phase watchdog for mem_port_arbiter; present only when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Terminal count fires on the cycle that would bring the count to TIMEOUT_CYCLES.
  assign cnt_d = cnt_q + 8'd1;
  assign tc_o  = en_i && (cnt_d == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= 8'd0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with alternating fairness.
// Optional ACCESS watchdog is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_rw,
  input  logic ls_req,
  input  logic ls_rw,
  input  logic MFC,
  output logic if_gnt,
  output logic ls_gnt,
  output logic if_done,
  output logic ls_done,
  output logic mem_EN,
  output logic mem_RW,
  output logic busy,
  output logic timeout_err
);
  import mem_ctrl_pkg::*;

  // Handshake: a requester holds req until its done pulse (or drops it to cancel); gnt is high
  // while it owns the port, and done is a single-cycle pulse in RELEASE after MFC.
  arb_state_e state_q;
  owner_e     owner_q, last_owner_q, winner;
  logic       rw_q, owner_req, tc;
  logic       if_gnt_q, ls_gnt_q, if_done_q, ls_done_q;
  logic       mem_en_q, mem_rw_q, busy_q, timeout_err_q;

  always_comb begin
    winner = OWN_IF;
    if (if_req && ls_req) begin
      winner = (last_owner_q == OWN_IF) ? OWN_LS : OWN_IF;
    end else if (ls_req) begin
      winner = OWN_LS;
    end
  end

  assign owner_req = (owner_q == OWN_LS) ? ls_req : if_req;

`ifdef MEM_TIMEOUT_EN
  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (state_q != ARB_ACCESS),
    .en_i    ((state_q == ARB_ACCESS) && !MFC),
    .tc_o    (tc)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign tc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= OWN_IF;
      last_owner_q  <= OWN_IF;
      rw_q          <= 1'b0;
      if_gnt_q      <= 1'b0;
      ls_gnt_q      <= 1'b0;
      if_done_q     <= 1'b0;
      ls_done_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_rw_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if_done_q     <= 1'b0;
      ls_done_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (if_req || ls_req) begin
            state_q  <= ARB_GRANT;
            owner_q  <= winner;
            rw_q     <= (winner == OWN_LS) ? ls_rw : if_rw;
            if_gnt_q <= (winner == OWN_IF);
            ls_gnt_q <= (winner == OWN_LS);
            busy_q   <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (!owner_req) begin
            state_q  <= ARB_RELEASE;
            if_gnt_q <= 1'b0;
            ls_gnt_q <= 1'b0;
          end else begin
            state_q  <= ARB_ACCESS;
            mem_en_q <= 1'b1;
            mem_rw_q <= (rw_q == MEM_READ);
          end
        end
        ARB_ACCESS: begin
          // Priority: completion, then cancel, then watchdog abort.
          if (MFC || !owner_req || tc) begin
            state_q  <= ARB_RELEASE;
            if_gnt_q <= 1'b0;
            ls_gnt_q <= 1'b0;
            mem_en_q <= 1'b0;
            mem_rw_q <= 1'b0;
            if (MFC) begin
              if_done_q <= (owner_q == OWN_IF);
              ls_done_q <= (owner_q == OWN_LS);
            end else if (owner_req) begin
              timeout_err_q <= 1'b1;
            end
          end
        end
        ARB_RELEASE: begin
          state_q      <= ARB_IDLE;
          busy_q       <= 1'b0;
          last_owner_q <= owner_q;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign if_gnt      = if_gnt_q;
  assign ls_gnt      = ls_gnt_q;
  assign if_done     = if_done_q;
  assign ls_done     = ls_done_q;
  assign mem_EN      = mem_en_q;
  assign mem_RW      = mem_rw_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
